// File: rtl/wallace_mac_pipe.sv
// Pipelined unsigned multiply-accumulate: Wallace-tree multiplier split by one
// register stage, followed by a dot-product accumulator with sticky overflow.
module wallace_mac_pipe #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);
  localparam int PW = 2 * WIDTH;
  localparam int NR = 3 * WIDTH;

  logic             en;
  logic [2:1]       vld_pipe_q, vld_pipe_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             last1_q, last1_d, last2_q, last2_d;
  logic [PW-1:0]    sum_row, carry_row;
  logic [PW-1:0]    s_row_q, s_row_d, c_row_q, c_row_d;
  logic [PW-1:0]    prod;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   sum;
  logic [CNT_W-1:0] cnt_inc;
  logic [ACC_W-1:0] acc_run_q, acc_run_d, out_acc_q, out_acc_d;
  logic             ovf_run_q, ovf_run_d, out_ovf_q, out_ovf_d;
  logic [CNT_W-1:0] cnt_run_q, cnt_run_d, out_count_q, out_count_d;
  logic             out_valid_q, out_valid_d;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    last1_d    = last1_q;
    s_row_d    = s_row_q;
    c_row_d    = c_row_q;
    last2_d    = last2_q;
    vld_pipe_d = vld_pipe_q;
    if (en) begin
      a_d        = in_a;
      b_d        = in_b;
      last1_d    = in_last;
      s_row_d    = sum_row;
      c_row_d    = carry_row;
      last2_d    = last1_q;
      vld_pipe_d = {vld_pipe_q[1], in_valid};
    end
  end

  // Wallace reduction: each level compresses row triples with 3:2 counters
  // until only a sum row and a carry row remain for the final adder.
  always_comb begin : tree
    logic [PW-1:0] r  [NR];
    logic [PW-1:0] nx [NR];
    int n, m;
    for (int i = 0; i < NR; i++) begin
      r[i]  = '0;
      nx[i] = '0;
    end
    for (int i = 0; i < WIDTH; i++)
      r[i] = b_q[i] ? (PW'(a_q) << i) : '0;
    n = WIDTH;
    for (int lvl = 0; lvl < WIDTH; lvl++) begin
      if (n > 2) begin
        m = 0;
        for (int i = 0; i < NR; i++) nx[i] = '0;
        for (int j = 0; j < WIDTH; j++) begin
          if (3 * j + 2 < n) begin
            nx[m]     = r[3*j] ^ r[3*j+1] ^ r[3*j+2];
            nx[m + 1] = ((r[3*j] & r[3*j+1]) | (r[3*j] & r[3*j+2]) |
                         (r[3*j+1] & r[3*j+2])) << 1;
            m = m + 2;
          end else if (3 * j < n) begin
            nx[m] = r[3*j];
            m = m + 1;
            if (3 * j + 1 < n) begin
              nx[m] = r[3*j+1];
              m = m + 1;
            end
          end
        end
        for (int i = 0; i < NR; i++) r[i] = nx[i];
        n = m;
      end
    end
    sum_row   = r[0];
    carry_row = r[1];
  end

  assign prod     = s_row_q + c_row_q;
  assign prod_ext = ACC_W'(prod);
  assign sum      = {1'b0, acc_run_q} + {1'b0, prod_ext};
  assign cnt_inc  = (cnt_run_q == '1) ? cnt_run_q : cnt_run_q + CNT_W'(1);

  always_comb begin
    acc_run_d   = acc_run_q;
    ovf_run_d   = ovf_run_q;
    cnt_run_d   = cnt_run_q;
    out_acc_d   = out_acc_q;
    out_ovf_d   = out_ovf_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (en && vld_pipe_q[2]) begin
      if (last2_q) begin
        out_acc_d   = sum[ACC_W-1:0];
        out_ovf_d   = ovf_run_q | sum[ACC_W];
        out_count_d = cnt_inc;
        out_valid_d = 1'b1;
        acc_run_d   = '0;
        ovf_run_d   = 1'b0;
        cnt_run_d   = '0;
      end else begin
        acc_run_d = sum[ACC_W-1:0];
        ovf_run_d = ovf_run_q | sum[ACC_W];
        cnt_run_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q  <= '0;
      a_q         <= '0;
      b_q         <= '0;
      last1_q     <= 1'b0;
      s_row_q     <= '0;
      c_row_q     <= '0;
      last2_q     <= 1'b0;
      acc_run_q   <= '0;
      ovf_run_q   <= 1'b0;
      cnt_run_q   <= '0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      a_q         <= a_d;
      b_q         <= b_d;
      last1_q     <= last1_d;
      s_row_q     <= s_row_d;
      c_row_q     <= c_row_d;
      last2_q     <= last2_d;
      acc_run_q   <= acc_run_d;
      ovf_run_q   <= ovf_run_d;
      cnt_run_q   <= cnt_run_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_ovf_q   <= out_ovf_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_ovf   = out_ovf_q;
  assign out_count = out_count_q;
endmodule

// File: tb/tb_wallace_mac_pipe.sv
// Four configurations share one handshake stream; each is checked against an
// arithmetic dot-product model (full-precision sum, then modulo/ovf/saturate).
module tb_wallace_mac_pipe;
  localparam int WV [4] = '{8, 8, 4, 16};
  localparam int AV [4] = '{24, 16, 10, 32};
  localparam int CV [4] = '{8, 8, 3, 3};

  typedef struct {
    longint acc;
    bit     ovf;
    longint cnt;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [15:0] in_a = '0, in_b = '0;
  logic [3:0]  rdy, ov, of;
  logic [23:0] acc0; logic [15:0] acc1; logic [9:0] acc2; logic [31:0] acc3;
  logic [7:0]  cnt0, cnt1; logic [2:0] cnt2, cnt3;
  logic [63:0] o_acc [4];
  logic [63:0] o_cnt [4];

  int   total = 0, bad = 0;
  res_t q [4][$];
  longint run_tot [4];
  longint run_cnt [4];
  bit   hold [4];
  logic [63:0] pa [4], pc [4];
  logic        po [4];

  always #5 clk = ~clk;

  wallace_mac_pipe #(.WIDTH(8), .ACC_W(24), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_a(in_a[7:0]),
    .in_b(in_b[7:0]), .in_last(in_last), .out_valid(ov[0]), .out_ready(out_ready),
    .out_acc(acc0), .out_ovf(of[0]), .out_count(cnt0));
  wallace_mac_pipe #(.WIDTH(8), .ACC_W(16), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_a(in_a[7:0]),
    .in_b(in_b[7:0]), .in_last(in_last), .out_valid(ov[1]), .out_ready(out_ready),
    .out_acc(acc1), .out_ovf(of[1]), .out_count(cnt1));
  wallace_mac_pipe #(.WIDTH(4), .ACC_W(10), .CNT_W(3)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_a(in_a[3:0]),
    .in_b(in_b[3:0]), .in_last(in_last), .out_valid(ov[2]), .out_ready(out_ready),
    .out_acc(acc2), .out_ovf(of[2]), .out_count(cnt2));
  wallace_mac_pipe #(.WIDTH(16), .ACC_W(32), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]), .in_a(in_a),
    .in_b(in_b), .in_last(in_last), .out_valid(ov[3]), .out_ready(out_ready),
    .out_acc(acc3), .out_ovf(of[3]), .out_count(cnt3));

  assign o_acc[0] = 64'(acc0); assign o_acc[1] = 64'(acc1);
  assign o_acc[2] = 64'(acc2); assign o_acc[3] = 64'(acc3);
  assign o_cnt[0] = 64'(cnt0); assign o_cnt[1] = 64'(cnt1);
  assign o_cnt[2] = 64'(cnt2); assign o_cnt[3] = 64'(cnt3);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_beat(input int k, input logic [15:0] a, input logic [15:0] b,
                            input bit last);
    longint am, bm, lim;
    res_t r;
    am = longint'(a) % (64'd1 << WV[k]);
    bm = longint'(b) % (64'd1 << WV[k]);
    run_tot[k] += am * bm;
    run_cnt[k] += 1;
    if (last) begin
      lim   = 64'd1 << AV[k];
      r.acc = run_tot[k] % lim;
      r.ovf = run_tot[k] >= lim;
      r.cnt = (run_cnt[k] > (64'd1 << CV[k]) - 1) ? (64'd1 << CV[k]) - 1 : run_cnt[k];
      q[k].push_back(r);
      run_tot[k] = 0;
      run_cnt[k] = 0;
    end
  endtask

  task automatic cyc(input bit v, input logic [15:0] a, input logic [15:0] b,
                     input bit l, input bit r);
    res_t e;
    in_valid = v; in_a = a; in_b = b; in_last = l; out_ready = r;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("in_ready[%0d]", k), 64'(rdy[k]), 64'(!ov[k] || r));
      if (hold[k]) begin
        chk($sformatf("stall_valid[%0d]", k), 64'(ov[k]), 64'd1);
        chk($sformatf("stall_acc[%0d]", k), o_acc[k], pa[k]);
        chk($sformatf("stall_ovf[%0d]", k), 64'(of[k]), 64'(po[k]));
        chk($sformatf("stall_cnt[%0d]", k), o_cnt[k], pc[k]);
      end
      if (v && rdy[k]) model_beat(k, a, b, l);
      if (ov[k] && r) begin
        if (q[k].size() == 0) chk($sformatf("spurious[%0d]", k), 64'd1, 64'd0);
        else begin
          e = q[k].pop_front();
          chk($sformatf("acc[%0d]", k), o_acc[k], 64'(e.acc));
          chk($sformatf("ovf[%0d]", k), 64'(of[k]), 64'(e.ovf));
          chk($sformatf("cnt[%0d]", k), o_cnt[k], 64'(e.cnt));
        end
      end
      hold[k] = ov[k] && !r;
      pa[k] = o_acc[k]; po[k] = of[k]; pc[k] = o_cnt[k];
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      run_tot[k] = 0; run_cnt[k] = 0; hold[k] = 0;
    end
  endtask

  task automatic idle();
    cyc(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
  endtask

  initial begin
    do_reset();
    chk("rst_valid", 64'(ov[0]), 64'd0);
    chk("rst_acc", o_acc[0], 64'd0);
    chk("rst_ovf", 64'(of[0]), 64'd0);
    chk("rst_cnt", o_cnt[0], 64'd0);
    chk("rst_ready", 64'(rdy[0]), 64'd1);

    // single beat, latency 2 edges, one-cycle visibility
    cyc(1'b1, 16'd255, 16'd255, 1'b1, 1'b1);
    idle();
    chk("lat_e1_valid", 64'(ov[0]), 64'd0);
    idle();
    chk("lat_e2_valid", 64'(ov[0]), 64'd1);
    chk("single_acc", o_acc[0], 64'd65025);
    chk("single_ovf", 64'(of[0]), 64'd0);
    chk("single_cnt", o_cnt[0], 64'd1);
    idle();
    chk("single_drop", 64'(ov[0]), 64'd0);

    // three-beat dot product
    cyc(1'b1, 16'd3, 16'd4, 1'b0, 1'b1);
    cyc(1'b1, 16'd5, 16'd6, 1'b0, 1'b1);
    cyc(1'b1, 16'd7, 16'd8, 1'b1, 1'b1);
    idle();
    chk("dot_early", 64'(ov[0]), 64'd0);
    idle();
    chk("dot_valid", 64'(ov[0]), 64'd1);
    chk("dot_acc", o_acc[0], 64'd98);
    chk("dot_cnt", o_cnt[0], 64'd3);

    // 16-bit accumulator wrap, then a fresh dot product
    cyc(1'b1, 16'd255, 16'd255, 1'b0, 1'b1);
    cyc(1'b1, 16'd255, 16'd255, 1'b1, 1'b1);
    idle(); idle();
    chk("wrap_acc", o_acc[1], 64'd64514);
    chk("wrap_ovf", 64'(of[1]), 64'd1);
    chk("wrap_acc24", o_acc[0], 64'd130050);
    cyc(1'b1, 16'd1, 16'd1, 1'b1, 1'b1);
    idle(); idle();
    chk("after_wrap_acc", o_acc[1], 64'd1);
    chk("after_wrap_ovf", 64'(of[1]), 64'd0);
    idle();

    // backpressure: junk beats offered during the stall must be refused
    cyc(1'b1, 16'd2, 16'd2, 1'b1, 1'b1);
    cyc(1'b1, 16'd3, 16'd3, 1'b1, 1'b1);
    cyc(1'b1, 16'd4, 16'd4, 1'b1, 1'b0);
    chk("bp_first", o_acc[0], 64'd4);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 16'd9, 16'd9, 1'b1, 1'b0);
      chk("bp_ready", 64'(rdy[0]), 64'd0);
      chk("bp_hold", o_acc[0], 64'd4);
    end
    idle();
    chk("bp_second", o_acc[0], 64'd9);
    idle();
    chk("bp_third", o_acc[0], 64'd16);
    idle();
    chk("bp_empty", 64'(ov[0]), 64'd0);

    // reset mid dot product
    cyc(1'b1, 16'd10, 16'd10, 1'b0, 1'b1);
    cyc(1'b1, 16'd20, 16'd20, 1'b0, 1'b1);
    do_reset();
    cyc(1'b1, 16'd2, 16'd3, 1'b1, 1'b1);
    idle(); idle();
    chk("rst_mid_acc", o_acc[0], 64'd6);
    chk("rst_mid_cnt", o_cnt[0], 64'd1);
    idle();

    // randomised burst
    for (int i = 0; i < 1000; i++)
      cyc($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
          $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
    for (int i = 0; i < 12; i++) idle();
    for (int k = 0; k < 4; k++)
      chk($sformatf("leftover[%0d]", k), 64'(q[k].size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
